// File: rtl/dff_async_reg.sv
`timescale 1ns/1ps
// Parameterised D flip-flop: async active-low reset, capture enable, complementary output.
// Define DFF_ASYNC_RST_SYNC_EN to add a SYNC_STAGES-deep reset-release synchronizer.
module dff_async_reg #(
    parameter int unsigned      WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0,
    parameter int unsigned      SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_qb
);

    logic             data_rst_n;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    if (WIDTH < 1 || SYNC_STAGES < 2) begin : g_param_check
        $error("dff_async_reg: WIDTH must be >= 1 and SYNC_STAGES >= 2");
    end

`ifdef DFF_ASYNC_RST_SYNC_EN
    // Assertion clears the chain at once; release walks a 1 through it before
    // the data flop leaves reset.
    logic [SYNC_STAGES-1:0] sync_d;
    logic [SYNC_STAGES-1:0] sync_q;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    assign data_rst_n = sync_q[SYNC_STAGES-1];
`else
    assign data_rst_n = reset;
`endif

    // An unknown enable falls to the else path, so it holds rather than smearing X.
    always_comb begin
        q_d = q_q;
        if (i_en) q_d = i_d;
    end

    always_ff @(posedge clk or negedge data_rst_n) begin
        if (!data_rst_n) q_q <= RESET_VAL;
        else             q_q <= q_d;
    end

    assign o_q  = q_q;
    assign o_qb = ~q_q;

endmodule

// File: tb/tb_dff_async_reg.sv
`timescale 1ns/1ps
// Directed + random bench for dff_async_reg: scoreboard of expected outputs,
// one 1-bit instance (RESET_VAL 0) and one 8-bit instance (RESET_VAL A5) in lockstep.
module tb_dff_async_reg;

`ifdef DFF_ASYNC_RST_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam logic [7:0] RV8 = 8'hA5;

    typedef struct {
        logic       q1;
        logic [7:0] q8;
        string      tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic       d1 = 1'b0;
    logic [7:0] d8 = 8'h00;
    logic       q1, qb1;
    logic [7:0] q8, qb8;

    exp_t sbq[$];
    logic       m1 = 1'b0;
    logic [7:0] m8 = 8'h00;
    int         hold_cnt = 0;
    int         n_chk = 0;
    int         n_fail = 0;

    dff_async_reg #(.WIDTH(1), .RESET_VAL(1'b0), .SYNC_STAGES(2)) u_dut1 (
        .clk(clk), .reset(rst_n), .i_en(en), .i_d(d1), .o_q(q1), .o_qb(qb1)
    );

    dff_async_reg #(.WIDTH(8), .RESET_VAL(RV8), .SYNC_STAGES(2)) u_dut8 (
        .clk(clk), .reset(rst_n), .i_en(en), .i_d(d8), .o_q(q8), .o_qb(qb8)
    );

    task automatic push_exp(input string tag);
        exp_t e;
        e.q1 = m1;
        e.q8 = m8;
        e.tag = tag;
        sbq.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        if (sbq.size() == 0) begin
            n_chk++;
            n_fail++;
            $error("FAIL scoreboard_empty got 0 entries want 1");
            return;
        end
        e = sbq.pop_front();
        n_chk++;
        assert (q1 === e.q1) else begin
            n_fail++;
            $error("FAIL %s q1 got %b want %b", e.tag, q1, e.q1);
        end
        n_chk++;
        assert (qb1 === ~e.q1) else begin
            n_fail++;
            $error("FAIL %s qb1 got %b want %b", e.tag, qb1, ~e.q1);
        end
        n_chk++;
        assert (q8 === e.q8) else begin
            n_fail++;
            $error("FAIL %s q8 got %h want %h", e.tag, q8, e.q8);
        end
        n_chk++;
        assert (qb8 === ~e.q8) else begin
            n_fail++;
            $error("FAIL %s qb8 got %h want %h", e.tag, qb8, ~e.q8);
        end
    endtask

    // Reset change with the clock parked low; outputs must react with no edge.
    task automatic set_rst(input logic v, input string tag);
        rst_n = v;
        if (!v) begin
            m1 = 1'b0;
            m8 = RV8;
            hold_cnt = LAT;
        end
        push_exp(tag);
        #1;
        check_pop();
    endtask

    // Drive inputs, advance the model across one rising edge, compare after it.
    task automatic tick(input logic nd1, input logic [7:0] nd8, input logic ne,
                        input logic nrst, input string tag);
        d1 = nd1;
        d8 = nd8;
        en = ne;
        rst_n = nrst;
        if (!nrst) begin
            m1 = 1'b0;
            m8 = RV8;
            hold_cnt = LAT;
        end else if (hold_cnt > 0) begin
            hold_cnt--;
        end else if (ne === 1'b1) begin
            m1 = nd1;
            m8 = nd8;
        end
        push_exp(tag);
        #1 clk = 1'b1;
        #1;
        check_pop();
        clk = 1'b0;
        #1;
    endtask

    initial begin
        #2;
        set_rst(1'b0, "rst_async");
        tick(1'b1, 8'hFF, 1'b1, 1'b0, "rst_ignores_clk");
        set_rst(1'b1, "rst_release");
        for (int i = 0; i < LAT; i++) tick(1'b1, 8'h3C, 1'b1, 1'b1, "sync_hold");
        tick(1'b1, 8'h3C, 1'b1, 1'b1, "capture_1");
        tick(1'b0, 8'hC3, 1'b1, 1'b1, "capture_0");
        tick(1'b1, 8'h3C, 1'b1, 1'b1, "capture_1b");
        for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b0, 1'b1, "hold");
        set_rst(1'b0, "mid_rst");
        set_rst(1'b1, "mid_release");
        tick(1'b1, 8'h55, 1'b1, 1'b1, "post_rel_1");
        tick(1'b0, 8'hAA, 1'b1, 1'b1, "post_rel_2");
        tick(1'b1, 8'h0F, 1'b1, 1'b1, "post_rel_3");
        tick(1'b0, 8'hF0, 1'b1, 1'b1, "post_rel_4");
        for (int i = 0; i < 100; i++) begin
            tick(1'($urandom_range(1)), 8'($urandom), ($urandom_range(3) != 0),
                 ($urandom_range(7) != 0), "random");
        end
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
